// File: rtl/reg_xfer_arbiter.sv
// Round-robin arbiter that captures one of four register values and streams it
// LSB-first as BUS_W-bit beats over a valid/ready interface.
module reg_xfer_arbiter #(
  parameter int unsigned W0    = 8,
  parameter int unsigned W1    = 16,
  parameter int unsigned W2    = 4,
  parameter int unsigned W3    = 32,
  parameter int unsigned BUS_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req_i,
  input  logic [W0-1:0]    data0_i,
  input  logic [W1-1:0]    data1_i,
  input  logic [W2-1:0]    data2_i,
  input  logic [W3-1:0]    data3_i,
  output logic [3:0]       gnt_o,
  output logic [3:0]       done_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [BUS_W-1:0] out_data_o,
  output logic [1:0]       out_ch_o,
  output logic             out_last_o,
  output logic             busy_o
);

  localparam int unsigned B0   = (W0 + BUS_W - 1) / BUS_W;
  localparam int unsigned B1   = (W1 + BUS_W - 1) / BUS_W;
  localparam int unsigned B2   = (W2 + BUS_W - 1) / BUS_W;
  localparam int unsigned B3   = (W3 + BUS_W - 1) / BUS_W;
  localparam int unsigned B01  = (B0 > B1) ? B0 : B1;
  localparam int unsigned B23  = (B2 > B3) ? B2 : B3;
  localparam int unsigned MAXB = (B01 > B23) ? B01 : B23;
  localparam int unsigned SHW  = MAXB * BUS_W;
  localparam int unsigned CW   = $clog2(MAXB + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]     state;
  logic [1:0]     rr_ptr;
  logic [SHW-1:0] shift;
  logic [CW-1:0]  beats_left;

  logic [1:0]     pick;
  logic           found;
  logic [1:0]     idx;
  logic [SHW-1:0] cap;
  logic [CW-1:0]  pick_beats;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 1; i <= 4; i++) begin
      idx = rr_ptr + 2'(i);
      if (!found && req_i[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    cap        = '0;
    pick_beats = '0;
    case (pick)
      2'd0: begin cap[W0-1:0] = data0_i; pick_beats = CW'(B0); end
      2'd1: begin cap[W1-1:0] = data1_i; pick_beats = CW'(B1); end
      2'd2: begin cap[W2-1:0] = data2_i; pick_beats = CW'(B2); end
      default: begin cap[W3-1:0] = data3_i; pick_beats = CW'(B3); end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      rr_ptr     <= 2'd3;
      shift      <= '0;
      beats_left <= '0;
      out_ch_o   <= '0;
      gnt_o      <= '0;
    end else begin
      gnt_o <= '0;
      case (state)
        ST_IDLE: begin
          if (found) begin
            shift      <= cap;
            beats_left <= pick_beats;
            rr_ptr     <= pick;
            out_ch_o   <= pick;
            gnt_o      <= 4'b0001 << pick;
            state      <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (out_ready_i) begin
            shift      <= shift >> BUS_W;
            beats_left <= beats_left - CW'(1);
            if (beats_left == CW'(1)) state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign out_valid_o = (state == ST_SEND);
  assign busy_o      = (state == ST_SEND);
  assign out_data_o  = out_valid_o ? shift[BUS_W-1:0] : '0;
  assign out_last_o  = out_valid_o && (beats_left == CW'(1));
  assign done_o      = (state == ST_DONE) ? (4'b0001 << out_ch_o) : 4'b0000;

endmodule

// File: tb/tb_reg_xfer_arbiter.sv
// Directed bench for reg_xfer_arbiter: table of single transfers plus
// hand-written sequences for stalls, held requests and mid-transfer reset.
module tb_reg_xfer_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_i;
  logic [7:0]  data0_i;
  logic [15:0] data1_i;
  logic [3:0]  data2_i;
  logic [31:0] data3_i;
  logic [3:0]  gnt_o;
  logic [3:0]  done_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [7:0]  out_data_o;
  logic [1:0]  out_ch_o;
  logic        out_last_o;
  logic        busy_o;

  int checks   = 0;
  int failures = 0;

  reg_xfer_arbiter #(.W0(8), .W1(16), .W2(4), .W3(32), .BUS_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i),
    .data0_i(data0_i), .data1_i(data1_i), .data2_i(data2_i), .data3_i(data3_i),
    .gnt_o(gnt_o), .done_o(done_o), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .out_data_o(out_data_o), .out_ch_o(out_ch_o),
    .out_last_o(out_last_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [7:0]  d0;
    logic [15:0] d1;
    logic [3:0]  d2;
    logic [31:0] d3;
    int          ch;
    int          nb;
    logic [31:0] bytes;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},   {28'h0, gnt_o}, 32'h0);
    chk({tag, "_done"},  {28'h0, done_o}, 32'h0);
    chk({tag, "_valid"}, {31'h0, out_valid_o}, 32'h0);
    chk({tag, "_data"},  {24'h0, out_data_o}, 32'h0);
    chk({tag, "_ch"},    {30'h0, out_ch_o}, 32'h0);
    chk({tag, "_last"},  {31'h0, out_last_o}, 32'h0);
    chk({tag, "_busy"},  {31'h0, busy_o}, 32'h0);
  endtask

  // Called at a negedge in IDLE; returns at the following IDLE negedge.
  task automatic xfer(input logic [3:0] req, input int ch, input int nb,
                      input logic [31:0] bytes, input int stall_beat,
                      input int stall_cycles, input bit drop_req);
    int lat;
    logic [3:0] onehot;
    onehot = 4'b0001 << ch;
    req_i = req;
    out_ready_i = 1'b1;
    lat = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      lat++;
      if (gnt_o != 4'b0000) break;
    end
    chk("gnt", {28'h0, gnt_o}, {28'h0, onehot});
    chk("grant_latency", lat, 1);
    chk("busy_send", {31'h0, busy_o}, 32'h1);
    if (drop_req) begin
      req_i   = 4'b0000;
      data0_i = ~data0_i;
      data1_i = ~data1_i;
      data2_i = ~data2_i;
      data3_i = ~data3_i;
    end
    for (int b = 0; b < nb; b++) begin
      chk("valid", {31'h0, out_valid_o}, 32'h1);
      chk("beat_data", {24'h0, out_data_o}, {24'h0, bytes[8*b +: 8]});
      chk("last", {31'h0, out_last_o}, {31'h0, (b == nb - 1)});
      chk("ch", {30'h0, out_ch_o}, ch);
      chk("done_during_send", {28'h0, done_o}, 32'h0);
      if (b == stall_beat) begin
        out_ready_i = 1'b0;
        for (int s = 0; s < stall_cycles; s++) begin
          step();
          chk("stall_valid", {31'h0, out_valid_o}, 32'h1);
          chk("stall_data", {24'h0, out_data_o}, {24'h0, bytes[8*b +: 8]});
          chk("stall_last", {31'h0, out_last_o}, {31'h0, (b == nb - 1)});
          chk("stall_ch", {30'h0, out_ch_o}, ch);
        end
        out_ready_i = 1'b1;
      end
      step();
    end
    chk("done", {28'h0, done_o}, {28'h0, onehot});
    chk("done_valid", {31'h0, out_valid_o}, 32'h0);
    chk("done_busy", {31'h0, busy_o}, 32'h0);
    step();
    chk("idle_done", {28'h0, done_o}, 32'h0);
    chk("idle_gnt", {28'h0, gnt_o}, 32'h0);
    chk("idle_valid", {31'h0, out_valid_o}, 32'h0);
  endtask

  initial begin
    tbl[0] = '{4'b1000, 8'h00, 16'h0000, 4'h0, 32'hDEADBEEF, 3, 4, 32'hDEADBEEF};
    tbl[1] = '{4'b0100, 8'h00, 16'h0000, 4'hA, 32'h0,        2, 1, 32'h0000000A};
    tbl[2] = '{4'b0011, 8'h55, 16'h1234, 4'h0, 32'h0,        0, 1, 32'h00000055};
    tbl[3] = '{4'b0011, 8'h55, 16'h1234, 4'h0, 32'h0,        1, 2, 32'h00001234};
    tbl[4] = '{4'b1100, 8'h00, 16'h0000, 4'hF, 32'h01020304, 2, 1, 32'h0000000F};
    tbl[5] = '{4'b1100, 8'h00, 16'h0000, 4'hF, 32'h01020304, 3, 4, 32'h01020304};

    rst_n = 1'b0; req_i = '0; out_ready_i = 1'b1;
    data0_i = '0; data1_i = '0; data2_i = '0; data3_i = '0;
    @(negedge clk);
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk_all_zero("idle_no_req");

    foreach (tbl[i]) begin
      data0_i = tbl[i].d0; data1_i = tbl[i].d1;
      data2_i = tbl[i].d2; data3_i = tbl[i].d3;
      xfer(tbl[i].req, tbl[i].ch, tbl[i].nb, tbl[i].bytes, -1, 0, 1'b1);
    end

    // All channels requesting continuously: rr_ptr is 3 here, so ch0 leads.
    data0_i = 8'hA1; data1_i = 16'hB2C3; data2_i = 4'h5; data3_i = 32'h11223344;
    xfer(4'b1111, 0, 1, 32'h000000A1, -1, 0, 1'b0);
    xfer(4'b1111, 1, 2, 32'h0000B2C3, -1, 0, 1'b0);
    xfer(4'b1111, 2, 1, 32'h00000005, -1, 0, 1'b0);
    xfer(4'b1111, 3, 4, 32'h11223344, -1, 0, 1'b0);
    xfer(4'b1111, 0, 1, 32'h000000A1, -1, 0, 1'b1);

    // Downstream stall on the first beat of a two-beat transfer.
    data1_i = 16'h1234;
    xfer(4'b0010, 1, 2, 32'h00001234, 0, 3, 1'b1);

    // Data and request changed right after the grant must not affect the stream.
    data1_i = 16'hC0DE;
    xfer(4'b0010, 1, 2, 32'h0000C0DE, -1, 0, 1'b1);

    // Reset in the middle of a ch3 transfer.
    data3_i = 32'hDEADBEEF;
    req_i = 4'b1000;
    step();
    chk("rst_seq_gnt", {28'h0, gnt_o}, 32'h8);
    req_i = 4'b0000;
    step();
    step();
    chk("rst_seq_beat2", {24'h0, out_data_o}, 32'hAD);
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    @(negedge clk);
    chk("rst_no_done", {28'h0, done_o}, 32'h0);
    rst_n = 1'b1;
    step();
    chk("post_rst_done", {28'h0, done_o}, 32'h0);
    data0_i = 8'h3C; data3_i = 32'h99887766;
    xfer(4'b1001, 0, 1, 32'h0000003C, -1, 0, 1'b0);
    data3_i = 32'h99887766;
    xfer(4'b1001, 3, 4, 32'h99887766, -1, 0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
